// File: rtl/clefia_pkg.sv
// Shared CLEFIA key-schedule definitions: key-length codes, CON(k) initial
// values and word counts, the P/Q masks, the GF(2^16) x^-1 reduction term,
// and the constant-sequencer state encoding.
package clefia_pkg;

  localparam logic [1:0]  KEYLEN_128 = 2'b00;
  localparam logic [1:0]  KEYLEN_192 = 2'b01;
  localparam logic [1:0]  KEYLEN_256 = 2'b10;

  localparam logic [15:0] IV_128     = 16'h428A;
  localparam logic [15:0] IV_192     = 16'h7137;
  localparam logic [15:0] IV_256     = 16'hB5C0;

  localparam logic [6:0]  NCON_128   = 7'd60;
  localparam logic [6:0]  NCON_192   = 7'd84;
  localparam logic [6:0]  NCON_256   = 7'd92;

  localparam logic [15:0] P_CONST    = 16'hB7E1;
  localparam logic [15:0] Q_CONST    = 16'h243F;

  // x^16+x^15+x^13+x^11+x^5+x^4+1 folded for a right shift by one
  localparam logic [15:0] XINV_POLY  = 16'hD418;

  typedef enum logic [1:0] {IDLE, EVEN, ODD, DONE} con_state_e;

  // One buffered output word
  typedef struct packed {
    logic [31:0] data;
    logic [6:0]  idx;
    logic        last;
  } con_word_t;

endpackage

// File: rtl/con_gfmul_xinv.sv
// Combinational GF(2^16) multiply by x^-1 for the CLEFIA T register.
module con_gfmul_xinv
  import clefia_pkg::*;
(
  input  logic [15:0] t,
  output logic [15:0] t_next
);

  // Shift right, fold the dropped bit back through the reduction term
  always_comb t_next = {1'b0, t[15:1]} ^ (t[0] ? XINV_POLY : 16'h0000);

endmodule

// File: rtl/con_seq_ctrl.sv
// CLEFIA CON(k) constant sequencer. Walks T through x^-1 steps and streams
// an even/odd 32-bit constant pair per T value over valid/ready.
// Build option: CON_SKID_EN inserts a 2-entry output skid buffer so the
// generator only looks at buffer occupancy, never at the live con_ready.
module con_seq_ctrl #(
  parameter logic [15:0] P_CONST = 16'hB7E1,
  parameter logic [15:0] Q_CONST = 16'h243F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  key_len,
  output logic [31:0] con_data,
  output logic        con_valid,
  input  logic        con_ready,
  output logic [6:0]  con_idx,
  output logic        con_last,
  output logic        busy,
  output logic        done
);
  import clefia_pkg::*;

  con_state_e  state, state_nx;
  logic [15:0] t_q, t_mul, iv_sel;
  logic [6:0]  idx_q, n_q, n_sel;
  logic        key_ok;
  logic [31:0] gen_data;
  logic        gen_valid, gen_last, gen_adv, drained;

  con_gfmul_xinv u_xinv (.t(t_q), .t_next(t_mul));

  // Decode key length into IV and word count; reserved code blocks start
  always_comb begin
    key_ok = 1'b1;
    iv_sel = IV_128;
    n_sel  = NCON_128;
    case (key_len)
      KEYLEN_128: begin iv_sel = IV_128; n_sel = NCON_128; end
      KEYLEN_192: begin iv_sel = IV_192; n_sel = NCON_192; end
      KEYLEN_256: begin iv_sel = IV_256; n_sel = NCON_256; end
      default:    key_ok = 1'b0;
    endcase
  end

  // Format the current constant from T: even = {T^P, rotl1(~T)}, odd = {~T^Q, rotl8(T)}
  always_comb begin
    gen_data = 32'h0;
    case (state)
      EVEN:    gen_data = {t_q ^ P_CONST, ~t_q[14:0], ~t_q[15]};
      ODD:     gen_data = {~t_q ^ Q_CONST, t_q[7:0], t_q[15:8]};
      default: gen_data = 32'h0;
    endcase
  end

  assign gen_valid = (state == EVEN) || (state == ODD);
  assign gen_last  = gen_valid && (idx_q == n_q - 7'd1);

`ifdef CON_SKID_EN
  con_word_t head_q, tail_q, gen_w;
  logic [1:0] cnt_q;
  logic       push, pop;

  // Generator advances on registered occupancy only
  assign gen_adv = (cnt_q != 2'd2);
  assign drained = (cnt_q == 2'd0);
  assign push    = gen_valid && gen_adv;
  assign pop     = (cnt_q != 2'd0) && con_ready;
  assign gen_w   = '{data: gen_data, idx: idx_q, last: gen_last};

  // Two-entry FIFO; head drives the ports
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) head_q <= gen_w;
          else               tail_q <= gen_w;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b11: head_q <= gen_w;   // push implies cnt_q==1 here
        default: ;
      endcase
    end
  end

  assign con_valid = (cnt_q != 2'd0);
  assign con_data  = head_q.data;
  assign con_idx   = head_q.idx;
  assign con_last  = con_valid && head_q.last;
`else
  assign gen_adv   = con_ready;
  assign drained   = 1'b1;
  assign con_valid = gen_valid;
  assign con_data  = gen_data;
  assign con_idx   = idx_q;
  assign con_last  = gen_last;
`endif

  assign done = (state == DONE) && drained;
  assign busy = (state != IDLE) && !done;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state: start only honoured in IDLE with a legal key length
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start && key_ok) state_nx = EVEN;
      EVEN: if (gen_adv)         state_nx = ODD;
      ODD:  if (gen_adv)         state_nx = gen_last ? DONE : EVEN;
      DONE: if (drained)         state_nx = IDLE;
      default:                   state_nx = IDLE;
    endcase
  end

  // T, index and run length; index holds at n-1 on the final word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q   <= 16'h0;
      idx_q <= 7'd0;
      n_q   <= 7'd0;
    end else begin
      case (state)
        IDLE: if (start && key_ok) begin
          t_q   <= iv_sel;
          n_q   <= n_sel;
          idx_q <= 7'd0;
        end
        EVEN: if (gen_adv) idx_q <= idx_q + 7'd1;
        ODD: if (gen_adv) begin
          t_q <= t_mul;
          if (!gen_last) idx_q <= idx_q + 7'd1;
        end
        DONE: if (drained) idx_q <= 7'd0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_con_seq_ctrl.sv
// Randomized bench for con_seq_ctrl: expected streams come from a queue
// model of the CON(k) recurrence, compared word-for-word under backpressure.
module tb_con_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  key_len = 2'b00;
  logic        con_ready = 1'b0;
  logic [31:0] con_data;
  logic        con_valid;
  logic [6:0]  con_idx;
  logic        con_last;
  logic        busy;
  logic        done;

  int vecs = 0;
  int errs = 0;
  logic [31:0] exp_q[$];

  con_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len),
    .con_data(con_data), .con_valid(con_valid), .con_ready(con_ready),
    .con_idx(con_idx), .con_last(con_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] rl(input logic [15:0] x, input int s);
    return (x << s) | (x >> (16 - s));
  endfunction

  // Reference stream: pairs of constants per T, T stepped by x^-1 in GF(2^16)
  task automatic build(input logic [1:0] kl, output int n);
    logic [15:0] t;
    exp_q.delete();
    case (kl)
      2'b00:   begin t = 16'h428A; n = 60; end
      2'b01:   begin t = 16'h7137; n = 84; end
      default: begin t = 16'hB5C0; n = 92; end
    endcase
    for (int k = 0; k < n / 2; k++) begin
      exp_q.push_back({t ^ 16'hB7E1, rl(~t, 1)});
      exp_q.push_back({(~t) ^ 16'h243F, rl(t, 8)});
      t = (t >> 1) ^ (t[0] ? 16'hD418 : 16'h0000);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_data"},  con_data, 32'h0);
    chk({nm, "_valid"}, {31'h0, con_valid}, 32'h0);
    chk({nm, "_idx"},   {25'h0, con_idx}, 32'h0);
    chk({nm, "_last"},  {31'h0, con_last}, 32'h0);
    chk({nm, "_busy"},  {31'h0, busy}, 32'h0);
    chk({nm, "_done"},  {31'h0, done}, 32'h0);
  endtask

  // One run: rdy_pct = ready probability, poke_idx = idx at which start is
  // re-pulsed (-1 none), abort_idx = idx at which reset is asserted (-1 none)
  task automatic run(input logic [1:0] kl, input int rdy_pct, input int poke_idx, input int abort_idx);
    int n, ptr, cyc;
    bit last_hs, fin, stall;
    logic [31:0] pd;
    logic [6:0]  pi;
    build(kl, n);
    ptr = 0; cyc = 0; last_hs = 0; fin = 0; stall = 0; pd = '0; pi = '0;
    @(negedge clk);
    key_len = kl; start = 1'b1;
    con_ready = ($urandom_range(0, 99) < rdy_pct);
    stall = 0;
    @(negedge clk);
    start = 1'b0;
    while (!fin && cyc < 3000) begin
      if (last_hs) begin
        chk("done_pulse", {31'h0, done}, 32'h1);
        chk("busy_at_done", {31'h0, busy}, 32'h0);
        chk("valid_at_done", {31'h0, con_valid}, 32'h0);
        fin = 1;
      end else begin
        chk("done_low", {31'h0, done}, 32'h0);
        chk("busy_run", {31'h0, busy}, 32'h1);
        if (con_valid) begin
          vecs++;
          if (ptr >= n) begin
            errs++;
            $display("FAIL overrun: got word %0d expected at most %0d words", ptr, n);
          end else begin
            vecs--;
            chk("con_data", con_data, exp_q[ptr]);
            chk("con_idx", {25'h0, con_idx}, ptr);
            chk("con_last", {31'h0, con_last}, (ptr == n - 1) ? 32'h1 : 32'h0);
          end
          if (stall) begin
            chk("hold_data", con_data, pd);
            chk("hold_idx", {25'h0, con_idx}, {25'h0, pi});
          end
        end else if (stall) begin
          chk("valid_drop", {31'h0, con_valid}, 32'h1);
        end
        if (abort_idx >= 0 && con_valid && con_idx == abort_idx) begin
          #2 rst_n = 1'b0;
          #1 chk_reset_vals("abort");
          @(negedge clk);
          rst_n = 1'b1; start = 1'b0; con_ready = 1'b0;
          return;
        end
        start     = (poke_idx >= 0) && con_valid && (con_idx == poke_idx);
        con_ready = ($urandom_range(0, 99) < rdy_pct);
        stall     = con_valid && !con_ready;
        pd        = con_data;
        pi        = con_idx;
        if (con_valid && con_ready) begin
          if (ptr == n - 1) last_hs = 1;
          ptr++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    if (!fin) begin
      vecs++; errs++;
      $display("FAIL timeout: got %0d words expected %0d", ptr, n);
    end
    chk("word_count", ptr, n);
    // No restart from a start that arrived while busy or at the last handshake
    repeat (3) begin
      @(negedge clk);
      chk("idle_valid", {31'h0, con_valid}, 32'h0);
      chk("idle_busy", {31'h0, busy}, 32'h0);
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    // Pin the model to known constants
    build(2'b00, n);
    chk("model_128_con0", exp_q[0], 32'hF56B7AEB);
    chk("model_128_con1", exp_q[1], 32'h994A8A42);
    chk("model_128_con2_hi", {16'h0, exp_q[2][31:16]}, 32'h000096A4);
    chk("model_128_n", n, 60);
    build(2'b01, n);
    chk("model_192_con0", exp_q[0], 32'hC6D61D91);
    chk("model_192_n", n, 84);
    build(2'b10, n);
    chk("model_256_con0", exp_q[0], 32'h0221947E);
    chk("model_256_n", n, 92);

    run(2'b00, 100, -1, -1);
    run(2'b01, 100, -1, -1);
    run(2'b10, 100, -1, -1);
    run(2'b00, 55, -1, -1);
    run(2'b10, 30, -1, -1);
    run(2'b00, 60, 10, -1);     // mid-run start ignored
    run(2'b00, 100, 59, -1);    // start coincides with last handshake

    // Reserved key length
    @(negedge clk);
    key_len = 2'b11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      chk("rsv_busy", {31'h0, busy}, 32'h0);
      chk("rsv_valid", {31'h0, con_valid}, 32'h0);
      @(negedge clk);
    end

    run(2'b00, 70, -1, 31);     // reset mid-run
    run(2'b00, 100, -1, -1);    // fresh run after abort

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
